// File: rtl/i2s_tx.sv
// I2S transmitter: buffers one stereo pair ahead of the active frame and
// serialises 64-bit frames (32-bit left/right slots, one-bit WS delay) on a 64fs clock.
module i2s_tx #(
    parameter int WIDTH = 32
) (
    input  logic        clk_in,
    input  logic        rstn,
    input  logic [31:0] left_in,
    input  logic [31:0] right_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        underrun_clr,
    output logic        underrun,
    output logic        i2s_sclk,
    output logic        i2s_ws,
    output logic        i2s_sd
);

    localparam logic [31:0] SLOT_MASK = ~(32'hFFFF_FFFF >> WIDTH);

    logic [5:0]  cnt;
    logic [5:0]  cnt_nxt;
    logic [4:0]  bit_idx;
    logic        frame_load;
    logic        accept;
    logic        sd_nxt;
    logic [31:0] hold_l;
    logic [31:0] hold_r;
    logic        hold_full;
    logic [31:0] act_l;
    logic [31:0] act_r;

    assign i2s_sclk = ~clk_in;
    assign in_ready = ~hold_full;

    // Bit index is -cnt_nxt mod 32 for both slots; cycle 0 reuses it to emit R[0]
    // of the frame still held in act_r, which gives the one-bit I2S delay for free.
    always_comb begin
        cnt_nxt    = cnt + 6'd1;
        bit_idx    = 5'd0 - cnt_nxt[4:0];
        frame_load = (cnt == 6'd63);
        accept     = in_valid & ~hold_full;
        sd_nxt     = act_r[bit_idx];
        if ((cnt_nxt != 6'd0) && (cnt_nxt <= 6'd32)) begin
            sd_nxt = act_l[bit_idx];
        end
    end

    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            cnt    <= 6'd0;
            i2s_ws <= 1'b0;
            i2s_sd <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            i2s_ws <= cnt_nxt[5];
            i2s_sd <= sd_nxt;
        end
    end

    // Holding buffer drains into the active frame only on the frame-load edge;
    // an empty buffer there loads silence instead.
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            hold_l    <= 32'd0;
            hold_r    <= 32'd0;
            hold_full <= 1'b0;
            act_l     <= 32'd0;
            act_r     <= 32'd0;
        end else begin
            if (accept) begin
                hold_l    <= left_in & SLOT_MASK;
                hold_r    <= right_in & SLOT_MASK;
                hold_full <= 1'b1;
            end
            if (frame_load) begin
                if (hold_full) begin
                    act_l     <= hold_l;
                    act_r     <= hold_r;
                    hold_full <= 1'b0;
                end else begin
                    act_l <= 32'd0;
                    act_r <= 32'd0;
                end
            end
        end
    end

    // Setting on a starved frame-load edge takes priority over a clear request.
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            underrun <= 1'b0;
        end else if (frame_load && !hold_full) begin
            underrun <= 1'b1;
        end else if (underrun_clr) begin
            underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: a behavioural I2S receiver rebuilds frames from the
// serial lines, and received words are compared with hand-computed slots.
module tb_i2s_tx;

    logic        clk_in;
    logic        rstn;
    logic [31:0] left_in;
    logic [31:0] right_in;
    logic        in_valid;
    logic        underrun_clr;
    logic        in_ready, underrun, i2s_sclk, i2s_ws, i2s_sd;
    logic        in_ready16, underrun16, i2s_sclk16, i2s_ws16, i2s_sd16;

    int checks_total = 0;
    int checks_passed = 0;
    int cyc = 0;
    int ws_err = 0;

    logic [31:0] sr32, sr16, lw32, lw16;
    logic        ws_d;
    logic [31:0] rx_l32[$], rx_r32[$], rx_l16[$], rx_r16[$];

    typedef struct {
        int          cyc;
        logic [31:0] l;
        logic [31:0] r;
        logic [31:0] el32;
        logic [31:0] er32;
        logic [31:0] el16;
        logic [31:0] er16;
    } vec_t;

    vec_t vecs[6];
    logic [31:0] bp_l[4];
    logic [31:0] bp_r[4];

    i2s_tx #(.WIDTH(32)) dut (
        .clk_in(clk_in), .rstn(rstn), .left_in(left_in), .right_in(right_in),
        .in_valid(in_valid), .in_ready(in_ready), .underrun_clr(underrun_clr),
        .underrun(underrun), .i2s_sclk(i2s_sclk), .i2s_ws(i2s_ws), .i2s_sd(i2s_sd)
    );

    i2s_tx #(.WIDTH(16)) dut16 (
        .clk_in(clk_in), .rstn(rstn), .left_in(left_in), .right_in(right_in),
        .in_valid(in_valid), .in_ready(in_ready16), .underrun_clr(underrun_clr),
        .underrun(underrun16), .i2s_sclk(i2s_sclk16), .i2s_ws(i2s_ws16), .i2s_sd(i2s_sd16)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Receiver samples on i2s_sclk rising (mid-bit); a WS change marks the LSB of the previous word.
    always @(negedge clk_in) begin
        if (!rstn) begin
            sr32 = 32'd0;
            sr16 = 32'd0;
            ws_d = 1'b0;
            rx_l32.delete();
            rx_r32.delete();
            rx_l16.delete();
            rx_r16.delete();
        end else begin
            sr32 = {sr32[30:0], i2s_sd};
            sr16 = {sr16[30:0], i2s_sd16};
            if ((i2s_ws !== 1'(cyc >= 32)) || (i2s_ws16 !== i2s_ws)) ws_err++;
            if (i2s_ws != ws_d) begin
                if (i2s_ws) begin
                    lw32 = sr32;
                    lw16 = sr16;
                end else begin
                    rx_l32.push_back(lw32);
                    rx_r32.push_back(sr32);
                    rx_l16.push_back(lw16);
                    rx_r16.push_back(sr16);
                end
            end
            ws_d = i2s_ws;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
        cyc = (cyc + 1) % 64;
    endtask

    task automatic go_to(input int c);
        while (cyc != c) step();
    endtask

    task automatic wait_frame(output logic [31:0] l32, output logic [31:0] r32,
                              output logic [31:0] l16, output logic [31:0] r16);
        int n = 0;
        while (rx_l32.size() == 0 && n < 70) begin
            step();
            n++;
        end
        if (rx_l32.size() == 0) begin
            checks_total++;
            $display("[TB] FAIL frame_timeout: got no frame after %0d cycles, expected one", n);
            l32 = 'x; r32 = 'x; l16 = 'x; r16 = 'x;
        end else begin
            l32 = rx_l32.pop_front();
            r32 = rx_r32.pop_front();
            l16 = rx_l16.pop_front();
            r16 = rx_r16.pop_front();
        end
    endtask

    task automatic expect_zero_frame(input string name);
        logic [31:0] a, b, c, d;
        wait_frame(a, b, c, d);
        checkOutput(name, a | b | c | d, 32'd0);
    endtask

    task automatic applyStimulus(input logic [31:0] l, input logic [31:0] r, input logic v);
        left_in  = l;
        right_in = r;
        in_valid = v;
    endtask

    initial begin
        logic [31:0] l32, r32, l16, r16;
        int idx, steps, bp_err;
        logic acc;

        vecs[0] = '{10, 32'h1234_5678, 32'h9ABC_DEF0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h1234_0000, 32'h9ABC_0000};
        vecs[1] = '{1,  32'h1234_FFFF, 32'h8000_0001, 32'h1234_FFFF, 32'h8000_0001, 32'h1234_0000, 32'h8000_0000};
        vecs[2] = '{32, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_0000, 32'h0000_0000};
        vecs[3] = '{31, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_0000};
        vecs[4] = '{63, 32'hDEAD_BEEF, 32'hC0FF_EE11, 32'hDEAD_BEEF, 32'hC0FF_EE11, 32'hDEAD_0000, 32'hC0FF_0000};
        vecs[5] = '{62, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000};
        bp_l = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        bp_r = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};

        rstn = 1'b0;
        underrun_clr = 1'b0;
        applyStimulus(32'd0, 32'd0, 1'b0);
        #12;
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_underrun", {31'd0, underrun}, 32'd0);
        checkOutput("rst_ws", {31'd0, i2s_ws}, 32'd0);
        checkOutput("rst_sd", {31'd0, i2s_sd | i2s_sd16}, 32'd0);
        checkOutput("sclk_high", {31'd0, i2s_sclk}, {31'd0, ~clk_in});
        #5;
        checkOutput("sclk_low", {31'd0, i2s_sclk}, {31'd0, ~clk_in});

        @(posedge clk_in);
        #1;
        rstn = 1'b1;
        cyc = 0;

        // Basic transfer accepted at cycle 5
        go_to(5);
        checkOutput("basic_ready_before", {31'd0, in_ready}, 32'd1);
        applyStimulus(32'hA5A5_0000, 32'h0F0F_F00F, 1'b1);
        step();
        checkOutput("basic_ready_after", {31'd0, in_ready}, 32'd0);
        applyStimulus(32'd0, 32'd0, 1'b0);
        expect_zero_frame("basic_first_frame_zero");
        checkOutput("basic_no_underrun", {31'd0, underrun}, 32'd0);
        wait_frame(l32, r32, l16, r16);
        checkOutput("basic_left", l32, 32'hA5A5_0000);
        checkOutput("basic_right", r32, 32'h0F0F_F00F);
        checkOutput("basic_left16", l16, 32'hA5A5_0000);
        checkOutput("basic_right16", r16, 32'h0F0F_0000);

        // Underrun set, clear, and set-wins-over-clear with an accept on the load edge
        checkOutput("underrun_set", {31'd0, underrun}, 32'd1);
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        checkOutput("underrun_cleared", {31'd0, underrun}, 32'd0);
        expect_zero_frame("underrun_frame_zero");
        checkOutput("underrun_set_again", {31'd0, underrun}, 32'd1);
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        checkOutput("underrun_cleared_again", {31'd0, underrun}, 32'd0);
        go_to(63);
        underrun_clr = 1'b1;
        applyStimulus(32'h5A5A_C3C3, 32'h3C3C_1234, 1'b1);
        step();
        underrun_clr = 1'b0;
        applyStimulus(32'd0, 32'd0, 1'b0);
        checkOutput("underrun_set_wins", {31'd0, underrun}, 32'd1);
        checkOutput("load_edge_accept_ready", {31'd0, in_ready}, 32'd0);
        expect_zero_frame("load_edge_prev_zero");
        expect_zero_frame("load_edge_zero_frame");
        wait_frame(l32, r32, l16, r16);
        checkOutput("load_edge_left", l32, 32'h5A5A_C3C3);
        checkOutput("load_edge_right", r32, 32'h3C3C_1234);

        // Table-driven vectors; inputs toggle with valid high while the buffer is full
        for (int i = 0; i < 6; i++) begin
            go_to(vecs[i].cyc);
            applyStimulus(vecs[i].l, vecs[i].r, 1'b1);
            step();
            checkOutput($sformatf("vec%0d_ready", i), {31'd0, in_ready}, 32'd0);
            applyStimulus(~vecs[i].l, ~vecs[i].r, 1'b1);
            go_to(0);
            applyStimulus(32'd0, 32'd0, 1'b0);
            expect_zero_frame($sformatf("vec%0d_zero", i));
            if (vecs[i].cyc == 63) expect_zero_frame($sformatf("vec%0d_zero2", i));
            wait_frame(l32, r32, l16, r16);
            checkOutput($sformatf("vec%0d_left", i), l32, vecs[i].el32);
            checkOutput($sformatf("vec%0d_right", i), r32, vecs[i].er32);
            checkOutput($sformatf("vec%0d_left16", i), l16, vecs[i].el16);
            checkOutput($sformatf("vec%0d_right16", i), r16, vecs[i].er16);
        end

        // Back-pressure with valid held high
        idx = 0;
        steps = 0;
        bp_err = 0;
        applyStimulus(bp_l[0], bp_r[0], 1'b1);
        while (idx < 4 && steps < 400) begin
            acc = in_ready;
            step();
            steps++;
            if (acc) begin
                if (idx > 0 && cyc != 1) bp_err++;
                idx++;
                if (idx < 4) applyStimulus(bp_l[idx], bp_r[idx], 1'b1);
                else applyStimulus(32'd0, 32'd0, 1'b0);
            end
        end
        applyStimulus(32'd0, 32'd0, 1'b0);
        checkOutput("bp_accepts", idx, 32'd4);
        checkOutput("bp_accept_timing", bp_err, 32'd0);
        expect_zero_frame("bp_zero");
        for (int i = 0; i < 4; i++) begin
            wait_frame(l32, r32, l16, r16);
            checkOutput($sformatf("bp%0d_left", i), l32, bp_l[i]);
            checkOutput($sformatf("bp%0d_right", i), r32, bp_r[i]);
        end

        // Reset at cycle 40 with the holding buffer full
        go_to(5);
        applyStimulus(32'hFEED_FACE, 32'hBAAD_F00D, 1'b1);
        step();
        applyStimulus(32'd0, 32'd0, 1'b0);
        go_to(40);
        checkOutput("midrst_ws_before", {31'd0, i2s_ws}, 32'd1);
        rstn = 1'b0;
        #2;
        checkOutput("midrst_ready", {31'd0, in_ready & in_ready16}, 32'd1);
        checkOutput("midrst_underrun", {31'd0, underrun}, 32'd0);
        checkOutput("midrst_ws", {31'd0, i2s_ws}, 32'd0);
        checkOutput("midrst_sd", {31'd0, i2s_sd}, 32'd0);
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        rstn = 1'b1;
        cyc = 0;
        expect_zero_frame("midrst_zero1");
        checkOutput("midrst_underrun_after", {31'd0, underrun}, 32'd1);
        expect_zero_frame("midrst_zero2");

        checkOutput("ws_pattern_errors", ws_err, 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter WIDTH, default 32, significant sample bits (legal 16..32); left-justified in each 32-bit slot, unused LSBs transmitted as 0.
REQ-002 clk_in  input  1  64fs bit clock; all sequential logic on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 left_in  input  32  left sample; bits [31:32-WIDTH] used, remaining bits ignored.
REQ-005 right_in  input  32  right sample; same bit usage as left_in.
REQ-006 in_valid  input  1  left_in/right_in hold a valid stereo pair.
REQ-007 in_ready  output  1  holding buffer empty; pair accepted on a rising edge with in_valid=1 and in_ready=1.
REQ-008 underrun_clr  input  1  synchronous clear of underrun.
REQ-009 underrun  output  1  sticky flag: a frame was started without a buffered pair.
REQ-010 i2s_sclk  output  1  I2S bit clock, combinational ~clk_in.
REQ-011 i2s_ws  output  1  word select: 0 = left, 1 = right; registered.
REQ-012 i2s_sd  output  1  serial data, MSB first; registered.

Function
REQ-013 6-bit slot counter cnt increments every rising edge, wraps 63 -> 0; cycle c is the period after the edge that sets cnt=c.
REQ-014 Two storage stages: holding buffer (one pair plus full flag) and active frame register (one pair).
REQ-015 Accept edge (in_valid=1, in_ready=1): holding buffer captures both inputs, full flag set, in_ready=0 from the next cycle.
REQ-016 Frame-load edge = edge with cnt=63; holding full: active frame <= holding, full flag cleared, in_ready=1 from the next cycle.
REQ-017 Frame-load edge with holding empty: active frame <= all zeros, underrun <= 1.
REQ-018 No accept occurs on the frame-load edge when holding is full, because in_ready=0 then; an accept with holding empty on the frame-load edge fills holding only (that pair goes out one frame later), and the same edge still takes the zero/underrun path.
REQ-019 i2s_ws = 0 in cycles 0..31 and 1 in cycles 32..63 (transition one bit before each word's MSB).
REQ-020 i2s_sd in cycle c: c=1..32 -> L[32-c]; c=33..63 -> R[64-c]; c=0 -> R[0] of the previous frame (one-bit I2S delay).
REQ-021 Outputs change only on clk_in rising edges; the receiver samples on i2s_sclk rising edges (mid-bit).
REQ-022 underrun_clr=1 clears underrun on that edge; a simultaneous set (REQ-017) wins.
REQ-023 Sample inputs are not sampled outside accept edges; input changes while in_ready=0 have no effect.

Reset
REQ-024 rstn=0 immediately forces: cnt=0, i2s_ws=0, i2s_sd=0, in_ready=1, underrun=0, holding empty and zeroed, active frame zeroed, previous R[0]=0.
REQ-025 Reset asserted mid-frame aborts the frame; the buffered pair is discarded; after release, operation restarts at cycle 0 with zeros transmitted until the first frame-load edge.
REQ-026 i2s_sclk follows ~clk_in regardless of rstn.

Verification
REQ-027 Basic: after reset, present L=0xA5A5_0000, R=0x0F0F_F00F, valid=1 at cycle 5 -> in_ready=0 from cycle 6; in the next frame, sd cycles 1..32 = 0xA5A5_0000 MSB first, cycles 33..63 = R[31:1], next cycle 0 = 1; ws toggles at cycles 0 and 32.
REQ-028 Back-pressure: hold valid=1 with a new pair immediately after the accept -> no accept until the cycle after the frame-load edge; exactly one pair transmitted per 64 cycles, none lost or repeated.
REQ-029 Underrun: no valid through a frame-load edge -> following frame all zeros, underrun=1 from the next cycle; pulse underrun_clr -> underrun=0; underrun_clr on an underrun edge -> underrun stays 1.
REQ-030 WIDTH=16: L=0x1234_FFFF -> transmitted slot 0x1234_0000.
REQ-031 Reset mid-frame at cycle 40 with holding full -> all outputs at reset values immediately, in_ready=1, and the next frame transmits zeros.
REQ-032 Loopback: i2s_tx drives the existing 64fs I2S receiver from a common clk_in -> received left/right words equal transmitted pairs across 8 random frames.
